// File: rtl/ingress_pkt_buffer.sv
// Store-and-forward ingress packet buffer.
// Packets become visible downstream only once their EOP byte is stored.
module ingress_pkt_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic                       in_sop,
    input  logic                       in_eop,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_sop,
    output logic                       out_eop,
    output logic [$clog2(DEPTH):0]     pkt_count,
    output logic [CNT_W-1:0]           drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DISCARD
    } state_t;

    state_t st, st_nxt;

    logic [PW-1:0] wr_ptr, cmt_ptr, rd_ptr;
    logic [PW-1:0] wr_nxt, cmt_nxt, base;
    logic [AW-1:0] wr_addr;
    logic          wr_en;
    logic          commit;
    logic [1:0]    drop_inc;
    logic          full;
    logic          rd_fire;
    logic          rd_eop;
    logic [CNT_W:0] drop_sum;

    logic [DATA_W+1:0] mem [DEPTH];

    assign full      = (wr_ptr - rd_ptr) == DEPTH_P;
    assign out_valid = cmt_ptr != rd_ptr;
    assign {out_sop, out_eop, out_data} = mem[rd_ptr[AW-1:0]];
    assign rd_fire   = out_valid && out_ready;
    assign rd_eop    = rd_fire && out_eop;
    assign drop_sum  = {1'b0, drop_count} + (CNT_W+1)'(drop_inc);

    always_comb begin
        st_nxt   = st;
        wr_nxt   = wr_ptr;
        cmt_nxt  = cmt_ptr;
        wr_en    = 1'b0;
        wr_addr  = wr_ptr[AW-1:0];
        commit   = 1'b0;
        drop_inc = 2'd0;
        base     = wr_ptr;
        if (in_valid) begin
            if (in_sop) begin
                // A SOP mid-packet abandons the partial packet first
                if (st == RECV) begin
                    base     = cmt_ptr;
                    drop_inc = 2'd1;
                end
                if ((base - rd_ptr) != DEPTH_P) begin
                    wr_en   = 1'b1;
                    wr_addr = base[AW-1:0];
                    wr_nxt  = base + 1'b1;
                    if (in_eop) begin
                        cmt_nxt = base + 1'b1;
                        commit  = 1'b1;
                        st_nxt  = IDLE;
                    end else begin
                        st_nxt  = RECV;
                    end
                end else begin
                    wr_nxt   = base;
                    drop_inc = drop_inc + 2'd1;
                    st_nxt   = in_eop ? IDLE : DISCARD;
                end
            end else begin
                unique case (st)
                    RECV: begin
                        if (!full) begin
                            wr_en  = 1'b1;
                            wr_nxt = wr_ptr + 1'b1;
                            if (in_eop) begin
                                cmt_nxt = wr_ptr + 1'b1;
                                commit  = 1'b1;
                                st_nxt  = IDLE;
                            end
                        end else begin
                            wr_nxt   = cmt_ptr;
                            drop_inc = 2'd1;
                            st_nxt   = in_eop ? IDLE : DISCARD;
                        end
                    end
                    DISCARD: begin
                        if (in_eop) st_nxt = IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st         <= IDLE;
            wr_ptr     <= '0;
            cmt_ptr    <= '0;
            rd_ptr     <= '0;
            pkt_count  <= '0;
            drop_count <= '0;
        end else begin
            st      <= st_nxt;
            wr_ptr  <= wr_nxt;
            cmt_ptr <= cmt_nxt;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
            case ({commit, rd_eop})
                2'b10:   pkt_count <= pkt_count + 1'b1;
                2'b01:   pkt_count <= pkt_count - 1'b1;
                default: ;
            endcase
            if (drop_sum[CNT_W]) drop_count <= '1;
            else                 drop_count <= drop_sum[CNT_W-1:0];
        end
    end

    // Storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= {in_sop, in_eop, in_data};
    end

endmodule
